// File: rtl/alu_divider_seq_pkg.sv
// alu_divider_seq_pkg
//   Shared constants and types for the sequential ALU divider.
//   LEN_DATA     : index of the operand MSB (operands are LEN_DATA+1 bits wide)
//   OP_*         : execute-stage opcode encodings that select this unit
//   div_state_e  : divider control states
//   abs_val      : magnitude of an operand, honouring signed/unsigned mode
package alu_divider_seq_pkg;

  localparam int LEN_DATA = 63;
  localparam int W        = LEN_DATA + 1;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_e;

  // Two's-complement magnitude; the most negative value maps to 2^(W-1),
  // which is still representable as an unsigned W-bit number.
  function automatic logic [W-1:0] abs_val(input logic [W-1:0] v, input logic is_signed);
    abs_val = (is_signed && v[W-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/alu_divider_seq_div_step_cell.sv
// alu_divider_seq_div_step_cell
//   One restoring-division step: shift the partial remainder left by one,
//   pulling in the next dividend bit, and keep the trial difference when it
//   does not go negative.
//   rem_in      : current partial remainder (always < divisor_mag)
//   shift_in    : next dividend bit (MSB of the shifting dividend/quotient)
//   divisor_mag : divisor magnitude
//   rem_out     : next partial remainder
//   q_bit       : resolved quotient bit
module alu_divider_seq_div_step_cell
  import alu_divider_seq_pkg::*;
(
  input  logic [W-1:0] rem_in,
  input  logic         shift_in,
  input  logic [W-1:0] divisor_mag,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] diff;

  assign shifted = {rem_in, shift_in};
  // Because rem_in < divisor_mag, shifted < 2*divisor_mag, so the top bit of
  // the W+1-bit difference is a reliable "went negative" flag.
  assign diff    = shifted - {1'b0, divisor_mag};
  assign q_bit   = ~diff[W];
  assign rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/alu_divider_seq.sv
// alu_divider_seq
//   Iterative radix-2 restoring divider (signed or unsigned), one quotient
//   bit per clock. Request side uses req_valid/req_ready, result side uses
//   res_valid/res_ready. Results are held until consumed.
//   clk, rst               : clock, synchronous active-high reset
//   req_valid/req_ready    : request handshake (req_ready high only in IDLE)
//   req_signed             : 1 = two's-complement operands
//   dividend, divisor      : operands
//   res_valid/res_ready    : result handshake
//   quotient, remainder    : result (quotient truncates toward zero,
//                            remainder takes the dividend's sign)
//   div_by_zero            : divisor was zero, qualified by res_valid
module alu_divider_seq
  import alu_divider_seq_pkg::*;
#(
  parameter int ITER_PER_CYCLE = 1,
  parameter bit DIV0_Q_ONES    = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_signed,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int               CNT_W     = $clog2(W);
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(W / ITER_PER_CYCLE - 1);
  localparam logic [W-1:0]     MIN_NEG   = {1'b1, {(W-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic             res_valid_q, res_valid_d;
  logic [W-1:0]     quotient_q, quotient_d;
  logic [W-1:0]     remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             signed_q, signed_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     dq_q, dq_d;     // dividend shifts out the top, quotient in at the bottom
  logic [W-1:0]     bmag_q, bmag_d;

  logic [W-1:0]     step_rem;
  logic             step_qbit;

  alu_divider_seq_div_step_cell u_step (
    .rem_in      (rem_q),
    .shift_in    (dq_q[W-1]),
    .divisor_mag (bmag_q),
    .rem_out     (step_rem),
    .q_bit       (step_qbit)
  );

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    res_valid_d = res_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    signed_d    = signed_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    rem_d       = rem_q;
    dq_d        = dq_q;
    bmag_d      = bmag_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          a_d         = dividend;
          b_d         = divisor;
          signed_d    = req_signed;
          q_neg_d     = req_signed & (dividend[W-1] ^ divisor[W-1]);
          r_neg_d     = req_signed & dividend[W-1];
          req_ready_d = 1'b0;
          state_d     = ST_PREP;
        end
      end

      ST_PREP: begin
        if (b_q == '0) begin
          dbz_d       = 1'b1;
          quotient_d  = DIV0_Q_ONES ? '1 : '0;
          remainder_d = a_q;
          state_d     = ST_DONE;
        end else if (signed_q && (a_q == MIN_NEG) && (b_q == '1)) begin
          // Only signed case whose true quotient (+2^(W-1)) does not fit.
          dbz_d       = 1'b0;
          quotient_d  = MIN_NEG;
          remainder_d = '0;
          state_d     = ST_DONE;
        end else begin
          dbz_d   = 1'b0;
          rem_d   = '0;
          dq_d    = abs_val(a_q, signed_q);
          bmag_d  = abs_val(b_q, signed_q);
          cnt_d   = '0;
          state_d = ST_ITER;
        end
      end

      ST_ITER: begin
        rem_d = step_rem;
        dq_d  = {dq_q[W-2:0], step_qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ITER_LAST) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        quotient_d  = q_neg_q ? (~dq_q + 1'b1) : dq_q;
        remainder_d = r_neg_q ? (~rem_q + 1'b1) : rem_q;
        state_d     = ST_DONE;
      end

      ST_DONE: begin
        // res_valid rises one clock after entering DONE so the result
        // registers have settled before they are advertised.
        if (!res_valid_q) begin
          res_valid_d = 1'b1;
        end else if (res_ready) begin
          res_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        res_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      signed_q    <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      rem_q       <= '0;
      dq_q        <= '0;
      bmag_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      res_valid_q <= res_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      signed_q    <= signed_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      rem_q       <= rem_d;
      dq_q        <= dq_d;
      bmag_q      <= bmag_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign res_valid   = res_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_divider_seq.sv
module tb_alu_divider_seq;

  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;
  localparam int          LAT_NORMAL  = 67;
  localparam int          LAT_SPECIAL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_signed;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  alu_divider_seq #(
    .ITER_PER_CYCLE (1),
    .DIV0_Q_ONES    (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_signed  (req_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Behavioural reference: language-level division, with the two cases the
  // language leaves undefined handled from the architectural rules.
  task automatic ref_div(input logic [63:0] a, input logic [63:0] b, input logic s,
                         output logic [63:0] q, output logic [63:0] r, output logic z,
                         output int lat);
    z   = 1'b0;
    lat = LAT_NORMAL;
    if (b == 64'd0) begin
      z = 1'b1; q = ONES; r = a; lat = LAT_SPECIAL;
    end else if (s && a == MIN_NEG && b == ONES) begin
      q = MIN_NEG; r = 64'd0; lat = LAT_SPECIAL;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Drives one request (called #1 after an edge), waits for the result,
  // consumes it. Reports observed latency and handshake behaviour.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                       output logic [63:0] q, output logic [63:0] r, output logic z,
                       output int lat, output bit ready_ok, output bit drop_ok);
    ready_ok   = (req_ready === 1'b1);
    req_valid  = 1'b1;
    dividend   = a;
    divisor    = b;
    req_signed = s;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    dividend   = {$urandom, $urandom};
    divisor    = {$urandom, $urandom};
    req_signed = $urandom_range(0, 1);
    lat = 0;
    while (res_valid !== 1'b1 && lat < 200) begin
      if (req_ready !== 1'b0) ready_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (req_ready !== 1'b0) ready_ok = 1'b0;
    q = quotient;
    r = remainder;
    z = div_by_zero;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    drop_ok = (res_valid === 1'b0) && (req_ready === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0 || quotient !== 64'd0 ||
        remainder !== 64'd0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: req_ready=%b res_valid=%b q=%h r=%h dbz=%b, required 1 0 0 0 0",
               req_ready, res_valid, quotient, remainder, div_by_zero);
    end
    rst = 1'b0;
    $display("reset: req_ready=%b res_valid=%b", req_ready, res_valid);
  endtask

  task automatic test_directed();
    logic [63:0] a_t [5];
    logic [63:0] b_t [5];
    logic        s_t [5];
    logic [63:0] eq_t[5];
    logic [63:0] er_t[5];
    logic        ez_t[5];
    int          el_t[5];
    logic [63:0] q, r;
    logic        z;
    int          lat;
    bit          rok, dok;
    a_t[0] = 64'd100;                b_t[0] = 64'd7;    s_t[0] = 0; eq_t[0] = 64'd14;                 er_t[0] = 64'd2;                  ez_t[0] = 0; el_t[0] = 67;
    a_t[1] = 64'hFFFF_FFFF_FFFF_FF9C; b_t[1] = 64'd7;   s_t[1] = 1; eq_t[1] = 64'hFFFF_FFFF_FFFF_FFF2; er_t[1] = 64'hFFFF_FFFF_FFFF_FFFE; ez_t[1] = 0; el_t[1] = 67;
    a_t[2] = 64'd100; b_t[2] = 64'hFFFF_FFFF_FFFF_FFF9; s_t[2] = 1; eq_t[2] = 64'hFFFF_FFFF_FFFF_FFF2; er_t[2] = 64'd2;                  ez_t[2] = 0; el_t[2] = 67;
    a_t[3] = 64'h1234;               b_t[3] = 64'd0;    s_t[3] = 0; eq_t[3] = ONES;                   er_t[3] = 64'h1234;               ez_t[3] = 1; el_t[3] = 2;
    a_t[4] = MIN_NEG;                b_t[4] = ONES;     s_t[4] = 1; eq_t[4] = MIN_NEG;                er_t[4] = 64'd0;                  ez_t[4] = 0; el_t[4] = 2;
    for (int i = 0; i < 5; i++) begin
      do_op(a_t[i], b_t[i], s_t[i], q, r, z, lat, rok, dok);
      $display("directed %0d: %h / %h s=%b -> q=%h r=%h dbz=%b lat=%0d",
               i, a_t[i], b_t[i], s_t[i], q, r, z, lat);
      n_checks++;
      if (q !== eq_t[i]) begin n_fail++; $display("FAIL directed%0d quotient: got %h want %h", i, q, eq_t[i]); end
      n_checks++;
      if (r !== er_t[i]) begin n_fail++; $display("FAIL directed%0d remainder: got %h want %h", i, r, er_t[i]); end
      n_checks++;
      if (z !== ez_t[i]) begin n_fail++; $display("FAIL directed%0d div_by_zero: got %b want %b", i, z, ez_t[i]); end
      n_checks++;
      if (lat != el_t[i]) begin n_fail++; $display("FAIL directed%0d latency: got %0d want %0d", i, lat, el_t[i]); end
      n_checks++;
      if (!rok || !dok) begin n_fail++; $display("FAIL directed%0d handshake: ready_ok=%0b release_ok=%0b want 1 1", i, rok, dok); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] q0, r0, q, r;
    logic        z0, z;
    int          lat;
    bit          rok, dok;
    int          t;
    req_valid = 1'b1; dividend = 64'd100; divisor = 64'd7; req_signed = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    t = 0;
    while (res_valid !== 1'b1 && t < 200) begin @(posedge clk); #1; t++; end
    n_checks++;
    if (t != LAT_NORMAL) begin n_fail++; $display("FAIL backpressure latency: got %0d want %0d", t, LAT_NORMAL); end
    q0 = quotient; r0 = remainder; z0 = div_by_zero;
    for (int i = 0; i < 10; i++) begin
      req_valid  = 1'b1;
      dividend   = {$urandom, $urandom};
      divisor    = {$urandom, $urandom};
      req_signed = $urandom_range(0, 1);
      @(posedge clk); #1;
      n_checks++;
      if (res_valid !== 1'b1 || req_ready !== 1'b0 || quotient !== q0 || remainder !== r0 ||
          div_by_zero !== z0 || q0 !== 64'd14 || r0 !== 64'd2) begin
        n_fail++;
        $display("FAIL backpressure hold%0d: valid=%b ready=%b q=%h r=%h, want 1 0 q=e r=2",
                 i, res_valid, req_ready, quotient, remainder);
      end
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    $display("backpressure: held q=%h r=%h for 10 cycles", q0, r0);
    // The ignored pulses must not have queued a request.
    do_op(64'd7, 64'd2, 1'b0, q, r, z, lat, rok, dok);
    n_checks++;
    if (q !== 64'd3 || r !== 64'd1 || lat != LAT_NORMAL) begin
      n_fail++;
      $display("FAIL after_backpressure: q=%h r=%h lat=%0d want 3 1 67", q, r, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] q, r;
    logic        z;
    int          lat;
    bit          rok, dok;
    req_valid = 1'b1; dividend = 64'd1000; divisor = 64'd3; req_signed = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (31) @(posedge clk);   // PREP edge + 30 ITER edges: counter now 30
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0 || quotient !== 64'd0 ||
        remainder !== 64'd0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: req_ready=%b res_valid=%b q=%h r=%h dbz=%b want 1 0 0 0 0",
               req_ready, res_valid, quotient, remainder, div_by_zero);
    end
    $display("reset_mid: req_ready=%b res_valid=%b", req_ready, res_valid);
    do_op(ONES, 64'd3, 1'b0, q, r, z, lat, rok, dok);
    $display("after reset: q=%h r=%h lat=%0d", q, r, lat);
    n_checks++;
    if (q !== 64'h5555_5555_5555_5555 || r !== 64'd0 || z !== 1'b0 || lat != LAT_NORMAL) begin
      n_fail++;
      $display("FAIL reset_fresh_op: q=%h r=%h lat=%0d want 5555555555555555 0 67", q, r, lat);
    end
  endtask

  task automatic test_random_stream();
    logic [63:0] a, b, q, r, eq, er;
    logic        s, z, ez;
    int          lat, elat;
    bit          rok, dok;
    int          sel;
    for (int i = 0; i < 400; i++) begin
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      s   = $urandom_range(0, 1);
      sel = $urandom_range(0, 15);
      case (sel)
        0, 1:    b = 64'd1;
        2, 3:    a = 64'd0;
        4:       b = 64'd0;
        5:       b = ONES;
        6:       begin a = MIN_NEG; b = ONES; end
        7, 8:    b = {56'd0, b[7:0]};
        9:       begin a = {48'd0, a[15:0]}; b = {60'd0, b[3:0]} + 64'd1; end
        10:      b = {32'd0, b[31:0]};
        default: ;
      endcase
      ref_div(a, b, s, eq, er, ez, elat);
      do_op(a, b, s, q, r, z, lat, rok, dok);
      $display("rand %0d: %h / %h s=%b -> q=%h r=%h dbz=%b lat=%0d", i, a, b, s, q, r, z, lat);
      n_checks++;
      if (q !== eq || r !== er || z !== ez) begin
        n_fail++;
        $display("FAIL rand%0d result: q=%h r=%h dbz=%b want q=%h r=%h dbz=%b", i, q, r, z, eq, er, ez);
      end
      n_checks++;
      if (lat != elat) begin n_fail++; $display("FAIL rand%0d latency: got %0d want %0d", i, lat, elat); end
      n_checks++;
      if (!rok || !dok) begin n_fail++; $display("FAIL rand%0d handshake: ready_ok=%0b release_ok=%0b want 1 1", i, rok, dok); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] q, r;
    logic        z;
    int          lat;
    bit          rok, dok;
    // do_op leaves us #1 after the consume edge, so the next request is
    // presented for acceptance on the very next edge.
    do_op(64'd50, 64'd5, 1'b0, q, r, z, lat, rok, dok);
    do_op(64'hFFFF_FFFF_FFFF_FFCE, 64'd5, 1'b1, q, r, z, lat, rok, dok);
    $display("back_to_back: q=%h r=%h lat=%0d", q, r, lat);
    n_checks++;
    if (!rok || !dok || q !== 64'hFFFF_FFFF_FFFF_FFF6 || r !== 64'd0 || lat != LAT_NORMAL) begin
      n_fail++;
      $display("FAIL back_to_back: q=%h r=%h lat=%0d ready_ok=%0b want fffffffffffffff6 0 67 1",
               q, r, lat, rok);
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_signed = 1'b0;
    dividend   = 64'd0;
    divisor    = 64'd0;
    res_ready  = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
